// File: rtl/vga_frame_scanout_if.sv
// Frame buffer read bus between the scan-out engine (master) and the
// single-read-port frame buffer RAM (slave). Read data is expected one
// cycle after the row/column address is presented.
interface vga_frame_scanout_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_WIDTH  = 9,
  parameter int COL_WIDTH  = 10
) ();

  logic [ROW_WIDTH-1:0]  oReadRow;
  logic [COL_WIDTH-1:0]  oReadCol;
  logic [DATA_WIDTH-1:0] iPixelData;

  modport master (
    output oReadRow,
    output oReadCol,
    input  iPixelData
  );

  modport slave (
    input  oReadRow,
    input  oReadCol,
    output iPixelData
  );

endinterface

// File: rtl/vga_frame_scanout.sv
// vga_frame_scanout: 640x480@60 Hz raster scan-out engine.
// Generates VGA timing, drives frame buffer read addresses and converts the
// returned RGB565 words into blanked, sync-aligned pixel outputs. The RAM's
// one-cycle read latency is absorbed by a two-stage output pipeline so that
// colour, blank and sync leave the block on the same edge.
// Optional feature: define SCANOUT_TEST_PATTERN_EN to add iPatternEnable,
// which replaces RAM data with eight vertical colour bars.
module vga_frame_scanout #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_WIDTH  = 9,
  parameter int COL_WIDTH  = 10,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33
) (
  input  logic                Clock,
  input  logic                Reset,
  vga_frame_scanout_if.master fb,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic                iPatternEnable,
`endif
  output logic [4:0]          oRed,
  output logic [5:0]          oGreen,
  output logic [4:0]          oBlue,
  output logic                oHSync,
  output logic                oVSync,
  output logic                oBlank,
  output logic                oFrameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);

  localparam logic [HC_W-1:0] HC_LAST  = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] HC_VIS   = HC_W'(H_VISIBLE);
  localparam logic [HC_W-1:0] HS_BEGIN = HC_W'(H_VISIBLE + H_FRONT);
  localparam logic [HC_W-1:0] HS_END   = HC_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VC_W-1:0] VC_LAST  = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] VC_VIS   = VC_W'(V_VISIBLE);
  localparam logic [VC_W-1:0] VS_BEGIN = VC_W'(V_VISIBLE + V_FRONT);
  localparam logic [VC_W-1:0] VS_END   = VC_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Raster position and the position it advances to on the next edge
  logic [HC_W-1:0] hc_r, hc_nxt_s;
  logic [VC_W-1:0] vc_r, vc_nxt_s;
  logic            vis_nxt_s;

  // Read address registers (addresses move only with the counters)
  logic [ROW_WIDTH-1:0] row_r;
  logic [COL_WIDTH-1:0] col_r;

  // Stage 1: timing decoded from the current counter position
  logic vis_s, hsync_s, vsync_s, fs_s;
  logic vis1_r, hsync1_r, vsync1_r, fs1_r;

  // Stage 2 colour source
  logic [DATA_WIDTH-1:0] raw_s;
  logic [15:0]           pix_s;
  logic [15:0]           rgb_s;

`ifdef SCANOUT_TEST_PATTERN_EN
  localparam int BAR_W = H_VISIBLE / 8;

  logic [2:0] bar_s;
  logic [2:0] bar1_r;

  // Colour bar index for a visible column (eight bars of BAR_W pixels)
  function automatic logic [2:0] bar_of(input logic [HC_W-1:0] col);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      idx = (col >= HC_W'(i * BAR_W)) ? 3'(i) : idx;
    end
    return idx;
  endfunction

  // Full-scale RGB565 word for each bar, left to right
  function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
    logic [15:0] rgb;
    case (idx)
      3'd0:    rgb = 16'hFFFF; // white
      3'd1:    rgb = 16'hFFE0; // yellow
      3'd2:    rgb = 16'h07FF; // cyan
      3'd3:    rgb = 16'h07E0; // green
      3'd4:    rgb = 16'hF81F; // magenta
      3'd5:    rgb = 16'hF800; // red
      3'd6:    rgb = 16'h001F; // blue
      default: rgb = 16'h0000; // black
    endcase
    return rgb;
  endfunction
`endif

  // Next raster position: horizontal wrap advances the line, last line wraps to 0
  always_comb begin
    hc_nxt_s = hc_r + HC_W'(1);
    vc_nxt_s = vc_r;
    if (hc_r == HC_LAST) begin
      hc_nxt_s = '0;
      if (vc_r == VC_LAST) begin
        vc_nxt_s = '0;
      end else begin
        vc_nxt_s = vc_r + VC_W'(1);
      end
    end else begin
      vc_nxt_s = vc_r;
    end
    vis_nxt_s = (hc_nxt_s < HC_VIS) && (vc_nxt_s < VC_VIS);
  end

  // Raster counters; reset parks them at the first visible pixel
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      hc_r <= '0;
      vc_r <= '0;
    end else begin
      hc_r <= hc_nxt_s;
      vc_r <= vc_nxt_s;
    end
  end

  // Read address tracks the counter position, zero outside the visible area
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      row_r <= '0;
      col_r <= '0;
    end else if (vis_nxt_s) begin
      row_r <= ROW_WIDTH'(vc_nxt_s);
      col_r <= COL_WIDTH'(hc_nxt_s);
    end else begin
      row_r <= '0;
      col_r <= '0;
    end
  end

  assign fb.oReadRow = row_r;
  assign fb.oReadCol = col_r;

  // Decode visibility, sync windows and frame start at the current position
  always_comb begin
    vis_s   = (hc_r < HC_VIS) && (vc_r < VC_VIS);
    hsync_s = !((hc_r >= HS_BEGIN) && (hc_r <= HS_END));
    vsync_s = !((vc_r >= VS_BEGIN) && (vc_r <= VS_END));
    fs_s    = (hc_r == '0) && (vc_r == '0);
`ifdef SCANOUT_TEST_PATTERN_EN
    bar_s   = bar_of(hc_r);
`endif
  end

  // Stage 1: hold timing for one cycle while the RAM read is in flight
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      vis1_r   <= 1'b0;
      hsync1_r <= 1'b1;
      vsync1_r <= 1'b1;
      fs1_r    <= 1'b0;
`ifdef SCANOUT_TEST_PATTERN_EN
      bar1_r   <= 3'd0;
`endif
    end else begin
      vis1_r   <= vis_s;
      hsync1_r <= hsync_s;
      vsync1_r <= vsync_s;
      fs1_r    <= fs_s;
`ifdef SCANOUT_TEST_PATTERN_EN
      bar1_r   <= bar_s;
`endif
    end
  end

  assign raw_s = fb.iPixelData;

  // Select colour source and force black outside the visible area
  always_comb begin
    pix_s = raw_s[15:0];
`ifdef SCANOUT_TEST_PATTERN_EN
    if (iPatternEnable) begin
      pix_s = bar_rgb(bar1_r);
    end else begin
      pix_s = raw_s[15:0];
    end
`endif
    if (vis1_r) begin
      rgb_s = pix_s;
    end else begin
      rgb_s = 16'h0000;
    end
  end

  // Stage 2: register colour together with the delayed sync/blank/frame start
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      oRed        <= 5'd0;
      oGreen      <= 6'd0;
      oBlue       <= 5'd0;
      oHSync      <= 1'b1;
      oVSync      <= 1'b1;
      oBlank      <= 1'b1;
      oFrameStart <= 1'b0;
    end else begin
      oRed        <= rgb_s[15:11];
      oGreen      <= rgb_s[10:5];
      oBlue       <= rgb_s[4:0];
      oHSync      <= hsync1_r;
      oVSync      <= vsync1_r;
      oBlank      <= !vis1_r;
      oFrameStart <= fs1_r;
    end
  end

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Directed bench for vga_frame_scanout. Instance A uses full VGA timing for
// line-level and pixel-data checks; instance B uses a shrunken raster
// (30 x 15) so frame period, vsync and mid-frame reset fit in a short run.
`timescale 1ns/1ps
module tb_vga_frame_scanout;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic rst_a, rst_b;
  int total, bad;

  vga_frame_scanout_if fb_a ();
  vga_frame_scanout_if fb_b ();

  logic [4:0] a_red, b_red;
  logic [5:0] a_green, b_green;
  logic [4:0] a_blue, b_blue;
  logic a_hs, a_vs, a_blank, a_fs;
  logic b_hs, b_vs, b_blank, b_fs;

`ifdef SCANOUT_TEST_PATTERN_EN
  logic pat_a, pat_b;
`endif

  vga_frame_scanout dut_a (
    .Clock(Clock), .Reset(rst_a), .fb(fb_a),
`ifdef SCANOUT_TEST_PATTERN_EN
    .iPatternEnable(pat_a),
`endif
    .oRed(a_red), .oGreen(a_green), .oBlue(a_blue),
    .oHSync(a_hs), .oVSync(a_vs), .oBlank(a_blank), .oFrameStart(a_fs)
  );

  vga_frame_scanout #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_VISIBLE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_b (
    .Clock(Clock), .Reset(rst_b), .fb(fb_b),
`ifdef SCANOUT_TEST_PATTERN_EN
    .iPatternEnable(pat_b),
`endif
    .oRed(b_red), .oGreen(b_green), .oBlue(b_blue),
    .oHSync(b_hs), .oVSync(b_vs), .oBlank(b_blank), .oFrameStart(b_fs)
  );

  // Frame buffer models: 1-cycle registered read returning {row[7:0], col[7:0]}
  always @(posedge Clock) begin
    fb_a.iPixelData <= {fb_a.oReadRow[7:0], fb_a.oReadCol[7:0]};
    fb_b.iPixelData <= {fb_b.oReadRow[7:0], fb_b.oReadCol[7:0]};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [8:0] row, input logic [9:0] col,
                                       input logic [15:0] rgb, input logic hs,
                                       input logic vs, input logic blank, input logic fs);
    return {25'd0, row, col, rgb, hs, vs, blank, fs};
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    else return -1;
  endfunction

  int a_bfall[$], a_brise[$], a_hfall[$], a_hrise[$];
  int b_fsq[$], b_vfall[$], b_vrise[$];

  initial begin
    logic [63:0] reset_vec;
    logic p_ab, p_ah, p_bb, p_bv;
    int h, v, ha, va;
    logic vis, visa;
    logic [15:0] word;
    logic [8:0] erow;
    logic [9:0] ecol;

    total = 0;
    bad = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
`ifdef SCANOUT_TEST_PATTERN_EN
    pat_a = 1'b0;
    pat_b = 1'b0;
`endif
    reset_vec = pack(9'd0, 10'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);

    repeat (2) @(posedge Clock);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      check($sformatf("rst_a%0d", i),
            pack(fb_a.oReadRow, fb_a.oReadCol, {a_red, a_green, a_blue}, a_hs, a_vs, a_blank, a_fs),
            reset_vec);
    end
    check("rst_b", pack(fb_b.oReadRow, fb_b.oReadCol, {b_red, b_green, b_blue}, b_hs, b_vs, b_blank, b_fs),
          reset_vec);

    @(negedge Clock);
    rst_a = 1'b1;
    rst_b = 1'b1;
    p_ab = 1'b1; p_ah = 1'b1; p_bb = 1'b1; p_bv = 1'b1;

    for (int k = 1; k <= 3400; k++) begin
      @(posedge Clock); #1;

      // Instance A cycle-exact reference for the first two and a half lines
      if (k <= 2000) begin
        ha = k % 800; va = k / 800;
        visa = (ha < 640) && (va < 480);
        erow = visa ? 9'(va) : 9'd0;
        ecol = visa ? 10'(ha) : 10'd0;
        if (k < 2) begin
          check($sformatf("a_k%0d", k),
                pack(fb_a.oReadRow, fb_a.oReadCol, {a_red, a_green, a_blue}, a_hs, a_vs, a_blank, a_fs),
                pack(erow, ecol, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0));
        end else begin
          h = (k - 2) % 800; v = (k - 2) / 800;
          vis = (h < 640) && (v < 480);
          word = vis ? {8'(v), 8'(h)} : 16'h0000;
          check($sformatf("a_k%0d", k),
                pack(fb_a.oReadRow, fb_a.oReadCol, {a_red, a_green, a_blue}, a_hs, a_vs, a_blank, a_fs),
                pack(erow, ecol, word, !((h >= 656) && (h <= 751)), !((v >= 490) && (v <= 491)),
                     !vis, (h == 0) && (v == 0)));
        end
      end

      // Edge recording
      if (p_ab && !a_blank) a_bfall.push_back(k);
      if (!p_ab && a_blank) a_brise.push_back(k);
      if (p_ah && !a_hs) a_hfall.push_back(k);
      if (!p_ah && a_hs) a_hrise.push_back(k);
      if (p_bv && !b_vs) b_vfall.push_back(k);
      if (!p_bv && b_vs) b_vrise.push_back(k);
      if (b_fs) begin
        b_fsq.push_back(k);
        check($sformatf("b_fs_blank_k%0d", k), {62'd0, p_bb, b_blank}, 64'd2);
      end
      p_ab = a_blank; p_ah = a_hs; p_bb = b_blank; p_bv = b_vs;

      // Instance B: one-cycle reset at vc=5, hc=7 of its third frame
      if (k == 1057) rst_b = 1'b0;
      if (k == 1058) begin
        check("b_midreset",
              pack(fb_b.oReadRow, fb_b.oReadCol, {b_red, b_green, b_blue}, b_hs, b_vs, b_blank, b_fs),
              reset_vec);
        rst_b = 1'b1;
      end

`ifdef SCANOUT_TEST_PATTERN_EN
      if (k == 2401) pat_a = 1'b1;
      if (k == 2402) check("pat_px0_white", {48'd0, a_red, a_green, a_blue}, 64'hFFFF);
      if (k == 2482) check("pat_px80_yellow", {48'd0, a_red, a_green, a_blue}, 64'hFFE0);
      if (k == 2962) check("pat_px560_black", {48'd0, a_red, a_green, a_blue}, 64'h0000);
      if (k == 3100) pat_a = 1'b0;
`endif
      if (k == 3302) check("a_passthru_v4_h100", {48'd0, a_red, a_green, a_blue}, 64'h0464);
    end

    // Instance A line timing
    check("a_bfall0", 64'(qget(a_bfall, 0)), 64'd2);
    check("a_blank_len", 64'(qget(a_brise, 0) - qget(a_bfall, 0)), 64'd640);
    check("a_line_period", 64'(qget(a_bfall, 1) - qget(a_bfall, 0)), 64'd800);
    check("a_hs_offset", 64'(qget(a_hfall, 0) - qget(a_bfall, 0)), 64'd656);
    check("a_hs_width", 64'(qget(a_hrise, 0) - qget(a_hfall, 0)), 64'd96);
    check("a_hs_period", 64'(qget(a_hfall, 1) - qget(a_hfall, 0)), 64'd800);

    // Instance B frame timing, including the restart after mid-frame reset
    check("b_fs_count", 64'(b_fsq.size()), 64'd9);
    check("b_fs0", 64'(qget(b_fsq, 0)), 64'd2);
    check("b_fs1", 64'(qget(b_fsq, 1)), 64'd452);
    check("b_fs2", 64'(qget(b_fsq, 2)), 64'd902);
    check("b_fs_after_reset", 64'(qget(b_fsq, 3)), 64'd1060);
    check("b_fs_period_after_reset", 64'(qget(b_fsq, 4) - qget(b_fsq, 3)), 64'd450);
    check("b_vs_offset", 64'(qget(b_vfall, 0) - qget(b_fsq, 0)), 64'd300);
    check("b_vs_width", 64'(qget(b_vrise, 0) - qget(b_vfall, 0)), 64'd60);
    check("b_vs_after_reset", 64'(qget(b_vfall, 2)), 64'd1360);
    check("b_vs_width_after_reset", 64'(qget(b_vrise, 2) - qget(b_vfall, 2)), 64'd60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
